// File: rtl/fifo_rd_packer_pkg.sv
// ==========================================================================
// fifo_rd_packer_pkg: shared types for the FIFO read-side word packer (rev 1.0)
// ==========================================================================
`default_nettype none

package fifo_rd_packer_pkg;

  localparam int DW         = 8;
  localparam int PACK_N_DEF = 4;

  typedef logic [DW-1:0]            data_t;
  typedef logic [PACK_N_DEF*DW-1:0] pack_t;
  typedef logic [PACK_N_DEF-1:0]    keep_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } pk_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_rd_acc.sv
// ==========================================================================
// fifo_rd_acc: lane accumulator, captures one popped word per pend cycle (rev 1.0)
// ==========================================================================
`default_nettype none

module fifo_rd_acc
  import fifo_rd_packer_pkg::*;
#(
  parameter int PACK_N = PACK_N_DEF,
  parameter int ACW    = $clog2(PACK_N) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture,
  input  logic                 clear,
  input  logic [DW-1:0]        data,
  output logic [PACK_N*DW-1:0] pack_data,
  output logic [ACW-1:0]       count
);

  logic [DW-1:0] r_lanes [PACK_N];

  // Lanes are zeroed on clear so a partial beat carries zeros in unused lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < PACK_N; i++) r_lanes[i] <= '0;
    end else if (clear) begin
      count <= '0;
      for (int i = 0; i < PACK_N; i++) r_lanes[i] <= '0;
    end else if (capture) begin
      r_lanes[count[ACW-2:0]] <= data;
      count                   <= count + ACW'(1);
    end
  end

  for (genvar g = 0; g < PACK_N; g++) begin : g_lane
    assign pack_data[g*DW +: DW] = r_lanes[g];
  end

endmodule

`default_nettype wire

// File: rtl/fifo_rd_packer.sv
// ==========================================================================
// fifo_rd_packer: packs PACK_N FIFO words per stream beat, flush emits partial (rev 1.0)
// ==========================================================================
`default_nettype none

module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int PACK_N = PACK_N_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic [DW-1:0]        fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  output logic [PACK_N*DW-1:0] out_data,
  output logic [PACK_N-1:0]    out_keep,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic                 flush_done,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam int ACW = $clog2(PACK_N) + 1;

  pk_state_t             state;
  logic                  pend;
  logic [ACW-1:0]        acc_cnt;
  logic [PACK_N*DW-1:0]  acc_data;
  logic                  out_free;
  logic                  xfer;
  logic                  emit_load;
  logic                  acc_room;

  function automatic logic [PACK_N-1:0] keep_mask(input logic [ACW-1:0] n);
    logic [PACK_N-1:0] m;
    m = '0;
    for (int i = 0; i < PACK_N; i++) m[i] = (ACW'(i) < n);
    return m;
  endfunction

  assign out_free  = !out_valid || out_ready;
  assign xfer      = (acc_cnt == ACW'(PACK_N)) && out_free;
  assign emit_load = (state == EMIT) && out_free;
  assign acc_room  = ({1'b0, acc_cnt} + {{ACW{1'b0}}, pend}) < (ACW+1)'(PACK_N);

  // Counting the in-flight word keeps the accumulator from ever overfilling.
  assign fifo_pop  = !rd_rst && !fifo_empty && (state == RUN) && (acc_room || xfer);

  fifo_rd_acc #(
    .PACK_N (PACK_N),
    .ACW    (ACW)
  ) u_acc (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .capture   (pend),
    .clear     (xfer || emit_load),
    .data      (fifo_data),
    .pack_data (acc_data),
    .count     (acc_cnt)
  );

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state      <= RUN;
      pend       <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_valid  <= 1'b0;
      flush_done <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      pend       <= fifo_pop;
      flush_done <= 1'b0;

      if (out_valid && out_ready) beat_cnt <= beat_cnt + CNT_W'(1);

      if (xfer) begin
        out_data  <= acc_data;
        out_keep  <= '1;
        out_valid <= 1'b1;
      end else if (emit_load) begin
        out_data  <= acc_data;
        out_keep  <= keep_mask(acc_cnt);
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        RUN: begin
          if (flush) state <= DRAIN;
        end
        DRAIN: begin
          // Decide only once the last in-flight word has landed.
          if (!pend) begin
            if (acc_cnt == '0) begin
              state      <= DONE;
              flush_done <= 1'b1;
            end else if (acc_cnt == ACW'(PACK_N)) begin
              if (xfer) begin
                state      <= DONE;
                flush_done <= 1'b1;
              end
            end else begin
              state <= EMIT;
            end
          end
        end
        EMIT: begin
          if (emit_load) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
// ==========================================================================
// tb_fifo_rd_packer: FIFO model + scoreboard bench for the word packer (rev 1.0)
// ==========================================================================
`default_nettype none

module tb_fifo_rd_packer;
  import fifo_rd_packer_pkg::*;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [31:0]   out_data;
  logic [3:0]    out_keep;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic          flush_done;
  logic [15:0]   beat_cnt;

  fifo_rd_packer #(.PACK_N(4), .CNT_W(16)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .beat_cnt   (beat_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
  } beat_t;

  typedef struct {
    int          nw;
    logic [7:0]  base;
    logic [31:0] part;
    logic [3:0]  keep;
    int          lat;
  } fcase_t;

  beat_t      sb[$];
  logic [7:0] q[$];
  logic [7:0] exp_words[$];
  fcase_t     ft[6];

  int n_vec = 0;
  int n_err = 0;
  int viol = 0;
  int exp_bcnt = 0;
  int pop_cnt = 0;
  int valid_cnt = 0;
  logic last_pop;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] b);
    logic [31:0] d;
    q.push_back(b);
    fifo_empty = 1'b0;
    exp_words.push_back(b);
    if (exp_words.size() == 4) begin
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = exp_words[i];
      sb.push_back('{d, 4'hF});
      exp_words.delete();
    end
  endtask

  task automatic model_partial(output logic [31:0] d, output logic [3:0] k);
    d = '0;
    k = '0;
    for (int i = 0; i < exp_words.size(); i++) begin
      d[i*8 +: 8] = exp_words[i];
      k[i]        = 1'b1;
    end
  endtask

  task automatic check_outputs();
    beat_t e;
    if (fifo_pop && fifo_empty) viol++;
    if (out_valid) valid_cnt++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got data 0x%0h keep 0x%0h, none expected", out_data, out_keep);
      end else begin
        e = sb.pop_front();
        chk("beat_data", {32'h0, out_data}, {32'h0, e.data});
        chk("beat_keep", {60'h0, out_keep}, {60'h0, e.keep});
        chk("beat_cnt_acc", {48'h0, beat_cnt}, 64'(exp_bcnt));
        exp_bcnt = (exp_bcnt + 1) & 16'hFFFF;
      end
    end
  endtask

  // Called at a falling edge; the FIFO model updates 1ns after the rising edge.
  task automatic step();
    #1;
    check_outputs();
    last_pop = fifo_pop;
    if (last_pop) pop_cnt++;
    @(posedge rd_clk);
    #1;
    if (last_pop && q.size() != 0) fifo_data = q.pop_front();
    fifo_empty = (q.size() == 0);
    @(negedge rd_clk);
  endtask

  task automatic do_flush(input logic [31:0] part, input logic [3:0] keep, output int lat);
    if (keep != 4'h0) sb.push_back('{part, keep});
    exp_words.delete();
    flush = 1'b1;
    step();
    flush = 1'b0;
    lat = 1;
    while (!flush_done && lat < 12) begin
      step();
      lat++;
    end
    chk("flush_beat_visible", {63'h0, out_valid}, {63'h0, (keep != 4'h0)});
  endtask

  initial begin
    int lat;
    int p0;
    int v0;
    int bad;
    int changes;
    logic have;
    logic [31:0] held;
    logic [31:0] pd;
    logic [3:0]  pk;
    logic [7:0]  val;
    logic pop_hist [40];

    ft[0] = '{3, 8'h11, 32'h00332211, 4'h7, 3};
    ft[1] = '{0, 8'h00, 32'h00000000, 4'h0, 2};
    ft[2] = '{1, 8'h5A, 32'h0000005A, 4'h1, 3};
    ft[3] = '{2, 8'h30, 32'h00004130, 4'h3, 3};
    ft[4] = '{4, 8'h01, 32'h00000000, 4'h0, 2};
    ft[5] = '{6, 8'h10, 32'h00006554, 4'h3, 3};

    rd_rst     = 1'b1;
    fifo_data  = '0;
    fifo_empty = 1'b0;
    out_ready  = 1'b1;
    flush      = 1'b0;

    // Reset state, with a non-empty FIFO to prove pop is held off
    repeat (2) @(negedge rd_clk);
    #1;
    chk("rst_pop",        {63'h0, fifo_pop},   64'h0);
    chk("rst_valid",      {63'h0, out_valid},  64'h0);
    chk("rst_data",       {32'h0, out_data},   64'h0);
    chk("rst_keep",       {60'h0, out_keep},   64'h0);
    chk("rst_flush_done", {63'h0, flush_done}, 64'h0);
    chk("rst_beat_cnt",   {48'h0, beat_cnt},   64'h0);
    fifo_empty = 1'b1;
    @(negedge rd_clk);
    rd_rst = 1'b0;
    @(negedge rd_clk);

    // Two full beats from a preloaded FIFO, latency to first valid
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("t1_latency", 64'(lat), 64'd6);
    repeat (12) step();
    chk("t1_beat_cnt", {48'h0, beat_cnt}, 64'd2);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Continuous supply: 4-on/1-off pops, one beat per 5 cycles
    val = 8'h40;
    for (int c = 0; c < 40; c++) begin
      if (q.size() < 3) begin
        push_word(val);
        val = val + 8'h1;
      end
      if (c == 10) v0 = valid_cnt;
      step();
      pop_hist[c] = last_pop;
    end
    chk("t2_beats_30cyc", 64'(valid_cnt - v0), 64'd6);
    bad = 0;
    for (int c = 10; c <= 35; c++) begin
      int s;
      s = 0;
      for (int j = 0; j < 5; j++) s += int'(pop_hist[c+j]);
      if (s != 4) bad++;
    end
    chk("t2_pop_pattern", 64'(bad), 64'd0);
    chk("t2_no_pop_empty", 64'(viol), 64'd0);
    repeat (20) step();
    model_partial(pd, pk);
    do_flush(pd, pk, lat);
    chk("t2_flush_lat", 64'(lat), (pk != 4'h0) ? 64'd3 : 64'd2);
    repeat (3) step();

    // Flush table: partial beats, empty flush, flush after an exact full beat
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < ft[t].nw; i++) push_word(8'(ft[t].base + 8'(i * 8'h11)));
      repeat (12) step();
      do_flush(ft[t].part, ft[t].keep, lat);
      chk("tbl_flush_lat", 64'(lat), 64'(ft[t].lat));
      repeat (3) step();
      chk("tbl_sb_empty", 64'(sb.size()), 64'd0);
    end

    // Flush in the same cycle as a pop: that word joins the partial beat
    push_word(8'hC1);
    push_word(8'hC2);
    repeat (8) step();
    push_word(8'hC3);
    #1;
    chk("fp_pop_with_flush", {63'h0, fifo_pop}, 64'h1);
    do_flush(32'h00C3C2C1, 4'h7, lat);
    chk("fp_flush_lat", 64'(lat), 64'd4);
    repeat (3) step();

    // Backpressure: one beat held, a second accumulated, popping stops at 8
    out_ready = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 12; i++) push_word(8'h60 + 8'(i));
    have = 1'b0;
    held = '0;
    changes = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid) begin
        if (have && (out_data !== held || out_keep !== 4'hF)) changes++;
        held = out_data;
        have = 1'b1;
      end
    end
    chk("bp_pops", 64'(pop_cnt - p0), 64'd8);
    chk("bp_valid_held", {63'h0, out_valid}, 64'h1);
    chk("bp_stable", 64'(changes), 64'd0);
    chk("bp_held_data", {32'h0, held}, {32'h0, sb[0].data});
    out_ready = 1'b1;
    repeat (20) step();
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset with a held beat, acc_cnt=2 and a word in flight
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_word(8'h80 + 8'(i));
    repeat (8) step();
    chk("mr_valid_before", {63'h0, out_valid}, 64'h1);
    #2;
    rd_rst = 1'b1;
    #1;
    chk("mr_valid",      {63'h0, out_valid},  64'h0);
    chk("mr_data",       {32'h0, out_data},   64'h0);
    chk("mr_keep",       {60'h0, out_keep},   64'h0);
    chk("mr_beat_cnt",   {48'h0, beat_cnt},   64'h0);
    chk("mr_flush_done", {63'h0, flush_done}, 64'h0);
    chk("mr_pop",        {63'h0, fifo_pop},   64'h0);
    q.delete();
    sb.delete();
    exp_words.delete();
    exp_bcnt   = 0;
    fifo_empty = 1'b1;
    @(posedge rd_clk);
    @(negedge rd_clk);
    rd_rst    = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'hA1 + 8'(i));
    repeat (12) step();
    chk("mr_sb_empty", 64'(sb.size()), 64'd0);
    chk("mr_beat_cnt_after", {48'h0, beat_cnt}, 64'd1);

    chk("no_pop_while_empty", 64'(viol), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
